dsp_block_sequencer: RTL
========================

Name: dsp_block_sequencer

Overview:
- Parametrised block-level controller for the hybrid DSP core.
- On START, it sequences three phases for one block of samples:
  - LOAD: input buffer fill.
  - COMPUTE: core run, with length chosen by the transform select latched at START.
  - DRAIN: output buffer emptied under a valid/ready handshake.
- Sits between the host/stream interface and the input buffer, core datapath and output buffer.
- Generalises the fixed 8-sample input-enable controller with configurable block length, per-mode compute latency, output backpressure and status flags.

Parameters:
- BLK_LEN, 8: samples per block (LOAD and DRAIN length). Legal range 2..2^CNT_W.
- CNT_W, 16: width of SAMPLE_IDX and the internal sample counter.
- COMP_LAT, 4: base compute cycles. Actual compute length = COMP_LAT*(MODE+1).
- CMP_W, 8: width of the internal compute counter. Must hold 4*COMP_LAT.

Ports:
- CLK, input, 1: clock.
- RESET, input, 1: reset.
- START, input, 1: block start request.
- T_SELECT, input, 2: transform/mode select, sampled with START.
- OUT_READY, input, 1: downstream ready for output samples.
- IN_BUF_EN, output, 1: input buffer write enable.
- CORE_EN, output, 1: core compute enable.
- OUT_BUF_EN, output, 1: output buffer read enable.
- DATA_VALID, output, 1: output sample valid.
- SAMPLE_IDX, output, CNT_W: current sample index in LOAD/DRAIN. 0 otherwise.
- MODE, output, 2: latched T_SELECT for the current block.
- CORE_READY, output, 1: idle and able to accept START.
- BLK_DONE, output, 1: one-cycle pulse after the block's final transfer.

Behaviour:
- Reset:
  - Reset is RESET, synchronous, active-high; clock CLK.
  - After the reset edge: state IDLE, counters 0, MODE=0, BLK_DONE=0, CORE_READY=1, all enables and DATA_VALID 0.
  - RESET mid-operation aborts the block with no BLK_DONE. Reset values apply the next cycle.
- Output timing: all outputs are decoded from registered state/counters. No input reaches an output combinationally.
- States: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE:
  - CORE_READY=1.
  - START=1 at an edge moves to LOAD, latches MODE<=T_SELECT, clears the sample counter.
  - T_SELECT changes after that edge are ignored until the next START.
- LOAD:
  - IN_BUF_EN=1 for exactly BLK_LEN cycles. SAMPLE_IDX=0..BLK_LEN-1, +1 per cycle.
  - After index BLK_LEN-1, go to COMPUTE and clear the sample counter.
- COMPUTE:
  - CORE_EN=1 for exactly COMP_LAT*(MODE+1) cycles, then go to DRAIN.
  - SAMPLE_IDX=0.
- DRAIN:
  - OUT_BUF_EN=1 and DATA_VALID=1 for the whole state.
  - A transfer occurs in a cycle with DATA_VALID=1 and OUT_READY=1.
  - SAMPLE_IDX advances only on a transfer and holds while OUT_READY=0.
  - After the transfer at index BLK_LEN-1, go to IDLE.
- BLK_DONE:
  - Registered one-cycle pulse in the cycle after the final DRAIN transfer.
  - Coincides with the first IDLE cycle, where CORE_READY=1.
- Counters: compare against terminal values explicitly. No modulo-based termination and no wrap. Counter values beyond terminal are unreachable.
- START outside IDLE: ignored (but see the optional feature).
- START held high: back-to-back blocks separated by exactly one IDLE cycle.
- Minimum block period at full throughput: 2*BLK_LEN + COMP_LAT*(MODE+1) + 1 cycles.

Optional Feature:
- Macro: DSP_SEQ_START_QUEUE_EN.
- When defined, adds a one-deep pending-start register:
  - START seen while not IDLE captures a pending flag and the T_SELECT value.
  - A later START while pending is dropped; the first capture wins.
  - After the final DRAIN transfer, the FSM goes directly to LOAD with the queued mode and clears pending. BLK_DONE still pulses. CORE_READY stays 0.
  - RESET clears pending.
- When undefined: START outside IDLE is ignored; no extra state.

Test Plan:
- BLK_LEN=8, COMP_LAT=4, START pulsed at cycle 0 with T_SELECT=0, OUT_READY=1:
  - IN_BUF_EN cycles 1-8, SAMPLE_IDX 0..7.
  - CORE_EN cycles 9-12.
  - DATA_VALID cycles 13-20.
  - BLK_DONE and CORE_READY=1 at cycle 21.
- T_SELECT=3 at START, changed to 0 during LOAD: MODE=3, CORE_EN exactly 16 cycles.
- DRAIN with OUT_READY alternating 1,0 starting at 1: DRAIN lasts 15 cycles, SAMPLE_IDX holds on ready-low cycles, BLK_DONE one cycle after the 8th transfer.
- RESET asserted during COMPUTE cycle 10: next cycle all outputs at reset values, no BLK_DONE. A new START then gives LOAD from SAMPLE_IDX 0.
- START held high for 60 cycles, macro undefined: second LOAD begins at cycle 22 (one IDLE cycle at 21).
- START at cycle 5 (mid-LOAD) with T_SELECT=2:
  - Macro undefined: ignored.
  - Macro defined: second LOAD begins cycle 21 with MODE=2, CORE_READY stays 0, BLK_DONE pulses at 21.

Source files
------------

// File: rtl/dsp_block_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_block_sequencer
//
// Block-level controller for the hybrid DSP core. A START request runs one
// block through three phases:
//   LOAD    : input buffer fill, BLK_LEN cycles, SAMPLE_IDX 0..BLK_LEN-1
//   COMPUTE : core run for COMP_LAT*(MODE+1) cycles
//   DRAIN   : output buffer emptied under DATA_VALID/OUT_READY handshake
// It then returns to IDLE, pulsing BLK_DONE for one cycle.
//
// Optional feature (macro DSP_SEQ_START_QUEUE_EN):
//   Adds a one-deep pending-start register. A START seen outside IDLE is
//   remembered with its T_SELECT value. The FSM then goes straight from the
//   final DRAIN transfer into LOAD for the queued block. With the macro
//   undefined, START outside IDLE is ignored.
//
// Ports:
//   CLK        in   clock
//   RESET      in   synchronous, active-high reset
//   START      in   block start request
//   T_SELECT   in   [1:0] transform/mode select, sampled with START
//   OUT_READY  in   downstream ready for output samples
//   IN_BUF_EN  out  input buffer write enable (LOAD)
//   CORE_EN    out  core compute enable (COMPUTE)
//   OUT_BUF_EN out  output buffer read enable (DRAIN)
//   DATA_VALID out  output sample valid (DRAIN)
//   SAMPLE_IDX out  [CNT_W-1:0] sample index in LOAD/DRAIN, 0 otherwise
//   MODE       out  [1:0] T_SELECT latched for the current block
//   CORE_READY out  idle and able to accept START
//   BLK_DONE   out  one-cycle pulse after the block's final transfer
//
// Every output is decoded from registered state only. No input reaches an
// output through combinational logic.
// ---------------------------------------------------------------------------
module dsp_block_sequencer #(
  parameter int BLK_LEN  = 8,
  parameter int CNT_W    = 16,
  parameter int COMP_LAT = 4,
  parameter int CMP_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       T_SELECT,
  input  logic             OUT_READY,
  output logic             IN_BUF_EN,
  output logic             CORE_EN,
  output logic             OUT_BUF_EN,
  output logic             DATA_VALID,
  output logic [CNT_W-1:0] SAMPLE_IDX,
  output logic [1:0]       MODE,
  output logic             CORE_READY,
  output logic             BLK_DONE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(BLK_LEN - 1);

  // Last compute count for a given mode. The count runs 0..last, so the
  // phase lasts COMP_LAT*(mode+1) cycles.
  function automatic logic [CMP_W-1:0] cmp_last(input logic [1:0] m);
    int unsigned n;
    n = COMP_LAT * (int'(m) + 1) - 1;
    return n[CMP_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CMP_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             done_q, done_d;

  logic smp_at_last;
  logic cmp_at_last;
  logic xfer_last;

  assign smp_at_last = (smp_cnt_q == SMP_LAST);
  assign cmp_at_last = (cmp_cnt_q == cmp_last(mode_q));
  // Final handshake of the block: last index accepted downstream.
  assign xfer_last   = (state_q == DRAIN) && OUT_READY && smp_at_last;

`ifdef DSP_SEQ_START_QUEUE_EN
  logic       pend_q, pend_d;
  logic [1:0] pend_mode_q, pend_mode_d;
`endif

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
`ifdef DSP_SEQ_START_QUEUE_EN
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = LOAD;
          mode_d    = T_SELECT;
          smp_cnt_d = '0;
        end
      end

      LOAD: begin
        if (smp_at_last) begin
          state_d   = COMPUTE;
          smp_cnt_d = '0;
          cmp_cnt_d = '0;
        end else begin
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
        end
      end

      COMPUTE: begin
        if (cmp_at_last) begin
          state_d   = DRAIN;
          cmp_cnt_d = '0;
          smp_cnt_d = '0;
        end else begin
          cmp_cnt_d = cmp_cnt_q + CMP_W'(1);
        end
      end

      DRAIN: begin
        // Index only moves on an accepted transfer; holds under backpressure.
        if (OUT_READY) begin
          if (xfer_last) begin
            done_d    = 1'b1;
            state_d   = IDLE;
            smp_cnt_d = '0;
`ifdef DSP_SEQ_START_QUEUE_EN
            // Chain straight into the next block. A START arriving on this
            // very cycle is treated as if it had been queued.
            if (pend_q) begin
              state_d = LOAD;
              mode_d  = pend_mode_q;
              pend_d  = 1'b0;
            end else if (START) begin
              state_d = LOAD;
              mode_d  = T_SELECT;
            end
`endif
          end else begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef DSP_SEQ_START_QUEUE_EN
    // First request wins; later ones while pending are dropped.
    if ((state_q != IDLE) && START && !pend_q && !xfer_last) begin
      pend_d      = 1'b1;
      pend_mode_d = T_SELECT;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      cmp_cnt_q <= '0;
      mode_q    <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
    end
  end

`ifdef DSP_SEQ_START_QUEUE_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q      <= 1'b0;
      pend_mode_q <= 2'd0;
    end else begin
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
    end
  end
`endif

  assign IN_BUF_EN  = (state_q == LOAD);
  assign CORE_EN    = (state_q == COMPUTE);
  assign OUT_BUF_EN = (state_q == DRAIN);
  assign DATA_VALID = (state_q == DRAIN);
  assign SAMPLE_IDX = ((state_q == LOAD) || (state_q == DRAIN)) ? smp_cnt_q : '0;
  assign MODE       = mode_q;
  assign CORE_READY = (state_q == IDLE);
  assign BLK_DONE   = done_q;

endmodule
